// File: rtl/sram_phy_ctrl.sv
// Sequencer for an external 256Kx16 asynchronous SRAM: one read or write at a time, registered
// pad controls. Optional input-register capture of read data is enabled by SRAM_PHY_CTRL_IOB_RD_EN.
module sram_phy_ctrl #(
  parameter int unsigned WAIT_CYCLES = 1,
  parameter int unsigned TURN_CYCLES = 1
) (
  input  logic        a_clk,
  input  logic        a_rst,
  input  logic        sram_req,
  output logic        sram_ready,
  input  logic        sram_rd,
  input  logic [17:0] sram_addr,
  input  logic [1:0]  sram_be,
  input  logic [15:0] sram_wr_data,
  output logic        sram_rd_data_vld,
  output logic [15:0] sram_rd_data,
  output logic [17:0] ram_addr,
  output logic [15:0] ram_dout,
  output logic        ram_doe,
  input  logic [15:0] ram_din,
  output logic        ram_cs_n,
  output logic        ram_we_n,
  output logic        ram_oe_n,
  output logic        ram_ub_n,
  output logic        ram_lb_n
);

  typedef enum logic [2:0] {
    StIdle, StRd, StWrSetup, StWrPulse, StWrHold, StTurn
  } state_e;

  localparam int unsigned CntW = 5;
`ifdef SRAM_PHY_CTRL_IOB_RD_EN
  localparam int unsigned RdLoad = WAIT_CYCLES + 1;
`else
  localparam int unsigned RdLoad = WAIT_CYCLES;
`endif
  localparam int unsigned TurnLoad = (TURN_CYCLES == 0) ? 0 : TURN_CYCLES - 1;
  localparam logic [CntW-1:0] RdCnt    = CntW'(RdLoad);
  localparam logic [CntW-1:0] PulseCnt = CntW'(WAIT_CYCLES);
  localparam logic [CntW-1:0] TurnCnt  = CntW'(TurnLoad);

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [1:0]      be_q, be_d;
  logic [17:0]     addr_q, addr_d;
  logic [15:0]     dout_q, dout_d;
  logic [15:0]     rd_data_q, rd_data_d;
  logic            vld_q, vld_d;
  logic            ready_q, ready_d;
  logic            doe_q, doe_d;
  logic            cs_n_q, cs_n_d;
  logic            we_n_q, we_n_d;
  logic            oe_n_q, oe_n_d;
  logic            ub_n_q, ub_n_d;
  logic            lb_n_q, lb_n_d;
  logic            rd_done;
  logic            cs_act;
  logic [15:0]     din_src;

`ifdef SRAM_PHY_CTRL_IOB_RD_EN
  // Free-running capture so the flop can be packed into the input pad cell.
  logic [15:0] din_q;
  always_ff @(posedge a_clk) begin
    din_q <= ram_din;
  end
  assign din_src = din_q;
`else
  assign din_src = ram_din;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    be_d    = be_q;
    addr_d  = addr_q;
    dout_d  = dout_q;
    rd_done = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (ready_q && sram_req) begin
          addr_d = sram_addr;
          dout_d = sram_wr_data;
          be_d   = sram_be;
          if (sram_rd) begin
            state_d = StRd;
            cnt_d   = RdCnt;
          end else begin
            state_d = StWrSetup;
          end
        end
      end
      StRd: begin
        if (cnt_q == '0) begin
          state_d = StIdle;
          rd_done = 1'b1;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StWrSetup: begin
        state_d = StWrPulse;
        cnt_d   = PulseCnt;
      end
      StWrPulse: begin
        if (cnt_q == '0) state_d = StWrHold;
        else             cnt_d   = cnt_q - CntW'(1);
      end
      StWrHold: begin
        if (TURN_CYCLES == 0) begin
          state_d = StIdle;
        end else begin
          state_d = StTurn;
          cnt_d   = TurnCnt;
        end
      end
      StTurn: begin
        if (cnt_q == '0) state_d = StIdle;
        else             cnt_d   = cnt_q - CntW'(1);
      end
      default: state_d = StIdle;
    endcase
  end

  // Pad controls are decoded from the next state so every output comes straight from a flop.
  always_comb begin
    cs_act    = state_d inside {StRd, StWrSetup, StWrPulse, StWrHold};
    ready_d   = (state_d == StIdle);
    cs_n_d    = ~cs_act;
    oe_n_d    = (state_d != StRd);
    we_n_d    = (state_d != StWrPulse);
    doe_d     = state_d inside {StWrSetup, StWrPulse, StWrHold};
    ub_n_d    = ~(cs_act & be_d[1]);
    lb_n_d    = ~(cs_act & be_d[0]);
    vld_d     = rd_done;
    rd_data_d = rd_done ? din_src : rd_data_q;
  end

  always_ff @(posedge a_clk) begin
    if (a_rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      be_q      <= '0;
      addr_q    <= '0;
      dout_q    <= '0;
      rd_data_q <= '0;
      vld_q     <= 1'b0;
      ready_q   <= 1'b0;
      doe_q     <= 1'b0;
      cs_n_q    <= 1'b1;
      we_n_q    <= 1'b1;
      oe_n_q    <= 1'b1;
      ub_n_q    <= 1'b1;
      lb_n_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      be_q      <= be_d;
      addr_q    <= addr_d;
      dout_q    <= dout_d;
      rd_data_q <= rd_data_d;
      vld_q     <= vld_d;
      ready_q   <= ready_d;
      doe_q     <= doe_d;
      cs_n_q    <= cs_n_d;
      we_n_q    <= we_n_d;
      oe_n_q    <= oe_n_d;
      ub_n_q    <= ub_n_d;
      lb_n_q    <= lb_n_d;
    end
  end

  assign sram_ready       = ready_q;
  assign sram_rd_data_vld = vld_q;
  assign sram_rd_data     = rd_data_q;
  assign ram_addr         = addr_q;
  assign ram_dout         = dout_q;
  assign ram_doe          = doe_q;
  assign ram_cs_n         = cs_n_q;
  assign ram_we_n         = we_n_q;
  assign ram_oe_n         = oe_n_q;
  assign ram_ub_n         = ub_n_q;
  assign ram_lb_n         = lb_n_q;

endmodule

// File: tb/tb_sram_phy_ctrl.sv
// Directed bench for sram_phy_ctrl with a behavioural SRAM and a read-data scoreboard.
module tb_sram_phy_ctrl;

`ifdef SRAM_PHY_CTRL_IOB_RD_EN
  localparam int Iob = 1;
`else
  localparam int Iob = 0;
`endif

  logic a_clk = 1'b0;
  logic a_rst = 1'b1;
  always #5 a_clk = ~a_clk;

  logic        sram_req = 1'b0, sram_rd = 1'b0;
  logic [17:0] sram_addr = '0;
  logic [1:0]  sram_be = '0;
  logic [15:0] sram_wr_data = '0;
  logic        sram_ready, sram_rd_data_vld;
  logic [15:0] sram_rd_data;
  logic [17:0] ram_addr;
  logic [15:0] ram_dout, ram_din;
  logic        ram_doe, ram_cs_n, ram_we_n, ram_oe_n, ram_ub_n, ram_lb_n;

  // Second instance with zero wait/turnaround; its pad always returns a fixed word.
  logic        b_req = 1'b0, b_rd = 1'b0;
  logic        b_ready, b_vld, b_doe, b_cs_n, b_we_n, b_oe_n, b_ub_n, b_lb_n;
  logic [15:0] b_rd_data, b_dout;
  logic [17:0] b_addr;

  sram_phy_ctrl #(.WAIT_CYCLES(1), .TURN_CYCLES(1)) dut (
    .a_clk(a_clk), .a_rst(a_rst), .sram_req(sram_req), .sram_ready(sram_ready),
    .sram_rd(sram_rd), .sram_addr(sram_addr), .sram_be(sram_be), .sram_wr_data(sram_wr_data),
    .sram_rd_data_vld(sram_rd_data_vld), .sram_rd_data(sram_rd_data), .ram_addr(ram_addr),
    .ram_dout(ram_dout), .ram_doe(ram_doe), .ram_din(ram_din), .ram_cs_n(ram_cs_n),
    .ram_we_n(ram_we_n), .ram_oe_n(ram_oe_n), .ram_ub_n(ram_ub_n), .ram_lb_n(ram_lb_n)
  );

  sram_phy_ctrl #(.WAIT_CYCLES(0), .TURN_CYCLES(0)) dut0 (
    .a_clk(a_clk), .a_rst(a_rst), .sram_req(b_req), .sram_ready(b_ready),
    .sram_rd(b_rd), .sram_addr(18'h00055), .sram_be(2'b11), .sram_wr_data(16'h0f0f),
    .sram_rd_data_vld(b_vld), .sram_rd_data(b_rd_data), .ram_addr(b_addr),
    .ram_dout(b_dout), .ram_doe(b_doe), .ram_din(16'h1234), .ram_cs_n(b_cs_n),
    .ram_we_n(b_we_n), .ram_oe_n(b_oe_n), .ram_ub_n(b_ub_n), .ram_lb_n(b_lb_n)
  );

  int total = 0;
  int bad = 0;
  int viol = 0;
  int vld_seen = 0;
  int n_reads = 0;
  logic [15:0] exp_q[$];
  logic [15:0] mem [256];
  logic [15:0] ref_mem [256];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Behavioural SRAM: byte-masked writes while WE low, word read while CS and OE low.
  always @(posedge a_clk) begin
    if (!ram_cs_n && !ram_we_n) begin
      if (!ram_ub_n) mem[ram_addr[7:0]][15:8] <= ram_dout[15:8];
      if (!ram_lb_n) mem[ram_addr[7:0]][7:0]  <= ram_dout[7:0];
    end
  end

  always_comb begin
    ram_din = 16'hdead;
    if (!ram_cs_n && !ram_oe_n) ram_din = mem[ram_addr[7:0]];
  end

  always @(negedge a_clk) begin
    if (ram_doe && !ram_oe_n) viol++;
    if (sram_rd_data_vld) begin
      vld_seen++;
      if (exp_q.size() == 0) chk("vld_unexpected", 32'(sram_rd_data_vld), 32'd0);
      else chk("rd_data", 32'(sram_rd_data), 32'(exp_q.pop_front()));
    end
  end

  // Called at a negedge; returns at the negedge where ready is seen again.
  task automatic xfer(input logic rd, input logic [17:0] addr, input logic [1:0] be,
                      input logic [15:0] data, input logic hold_rd,
                      output int rdy_edge, output int we_lo, output int doe_hi,
                      output int oe_lo, output int vld_edge, output logic ub_seen,
                      output logic lb_seen);
    int n;
    n = 0;
    while (!sram_ready && n < 50) begin
      @(negedge a_clk);
      n++;
    end
    chk("ready_before_req", 32'(sram_ready), 32'd1);
    sram_req = 1'b1; sram_rd = rd; sram_addr = addr; sram_be = be; sram_wr_data = data;
    if (rd) begin
      exp_q.push_back(ref_mem[addr[7:0]]);
      n_reads++;
    end else begin
      if (be[1]) ref_mem[addr[7:0]][15:8] = data[15:8];
      if (be[0]) ref_mem[addr[7:0]][7:0]  = data[7:0];
    end
    @(posedge a_clk);
    rdy_edge = -1; we_lo = 0; doe_hi = 0; oe_lo = 0; vld_edge = -1;
    ub_seen = 1'b0; lb_seen = 1'b0;
    for (int k = 1; k <= 40 && rdy_edge < 0; k++) begin
      @(negedge a_clk);
      if (k == 1) begin
        if (hold_rd) begin
          sram_rd = 1'b1; sram_be = 2'b11;
        end else begin
          sram_req = 1'b0;
        end
      end
      if (!ram_we_n) we_lo++;
      if (ram_doe) doe_hi++;
      if (!ram_oe_n) oe_lo++;
      if (!ram_ub_n) ub_seen = 1'b1;
      if (!ram_lb_n) lb_seen = 1'b1;
      if (sram_rd_data_vld) vld_edge = k - 1;
      if (sram_ready) rdy_edge = k - 1;
    end
  endtask

  task automatic run0(input logic rd, output int rdy_edge, output int vld_edge);
    b_req = 1'b1; b_rd = rd;
    @(posedge a_clk);
    rdy_edge = -1; vld_edge = -1;
    for (int k = 1; k <= 20 && rdy_edge < 0; k++) begin
      @(negedge a_clk);
      if (k == 1) b_req = 1'b0;
      if (b_vld) vld_edge = k - 1;
      if (b_ready) rdy_edge = k - 1;
    end
  endtask

  initial begin
    int r, w, d, o, v, r0, v0;
    logic u, l;

    // Power-on reset
    repeat (3) @(negedge a_clk);
    chk("rst_ctrl", 32'({sram_ready, sram_rd_data_vld, ram_doe, ram_cs_n, ram_we_n,
                         ram_oe_n, ram_ub_n, ram_lb_n}), 32'h1f);
    chk("rst_data", 32'(sram_rd_data | ram_dout), 32'd0);
    a_rst = 1'b0;
    @(negedge a_clk);
    chk("ready_after_rst", 32'(sram_ready), 32'd1);

    // Full write, then read back
    xfer(1'b0, 18'h12345, 2'b11, 16'hbeef, 1'b0, r, w, d, o, v, u, l);
    chk("wr_ready_edge", r, 5);
    chk("wr_we_low", w, 2);
    chk("wr_doe_high", d, 4);
    chk("wr_strobes", 32'({u, l}), 32'h3);
    chk("wr_no_vld", v, -1);
    chk("mem_beef", 32'(mem[8'h45]), 32'hbeef);
    chk("ram_addr", 32'(ram_addr), 32'h12345);

    xfer(1'b1, 18'h12345, 2'b11, 16'h0000, 1'b0, r, w, d, o, v, u, l);
    chk("rd_ready_edge", r, 2 + Iob);
    chk("rd_vld_edge", v, 2 + Iob);
    chk("rd_oe_low", o, 2 + Iob);
    chk("rd_no_we", w, 0);

    // Upper-byte write
    xfer(1'b0, 18'h12345, 2'b10, 16'haa55, 1'b0, r, w, d, o, v, u, l);
    chk("bw_ready_edge", r, 5);
    chk("bw_strobes", 32'({u, l}), 32'h2);
    xfer(1'b1, 18'h12345, 2'b11, 16'h0000, 1'b0, r, w, d, o, v, u, l);
    chk("bw_rd_vld_edge", v, 2 + Iob);

    // Write with a read already held behind it
    xfer(1'b0, 18'h12345, 2'b11, 16'h1357, 1'b1, r, w, d, o, v, u, l);
    chk("held_wr_ready_edge", r, 5);
    chk("held_rd_pending", 32'({sram_req, sram_rd}), 32'h3);
    xfer(1'b1, 18'h12345, 2'b11, 16'h0000, 1'b0, r, w, d, o, v, u, l);
    chk("held_rd_ready_edge", r, 2 + Iob);

    // Zero wait / zero turnaround instance
    run0(1'b0, r0, v0);
    chk("w0_wr_ready_edge", r0, 3);
    chk("w0_wr_no_vld", v0, -1);
    run0(1'b1, r0, v0);
    chk("w0_rd_ready_edge", r0, 1 + Iob);
    chk("w0_rd_vld_edge", v0, 1 + Iob);
    chk("w0_rd_data", 32'(b_rd_data), 32'h1234);

    // Mid-idle reset clears held read data and address
    a_rst = 1'b1;
    repeat (3) @(negedge a_clk);
    chk("idle_rst_ctrl", 32'({sram_ready, sram_rd_data_vld, ram_doe, ram_cs_n, ram_we_n,
                              ram_oe_n, ram_ub_n, ram_lb_n}), 32'h1f);
    chk("idle_rst_data", 32'({sram_rd_data, ram_addr}), 32'd0);
    a_rst = 1'b0;
    @(negedge a_clk);
    chk("idle_rst_ready", 32'(sram_ready), 32'd1);

    // Reset during the WE pulse
    sram_req = 1'b1; sram_rd = 1'b0; sram_addr = 18'h00100; sram_be = 2'b11;
    sram_wr_data = 16'h5555;
    @(posedge a_clk);
    @(negedge a_clk);
    sram_req = 1'b0;
    @(negedge a_clk);
    chk("abort_in_pulse", 32'({ram_we_n, ram_doe}), 32'h1);
    a_rst = 1'b1;
    @(negedge a_clk);
    chk("abort_ctrl", 32'({ram_we_n, ram_doe, ram_cs_n, sram_ready}), 32'ha);
    a_rst = 1'b0;
    @(negedge a_clk);
    chk("abort_ready", 32'(sram_ready), 32'd1);

    xfer(1'b0, 18'h12345, 2'b11, 16'h2468, 1'b0, r, w, d, o, v, u, l);
    chk("post_abort_wr_edge", r, 5);
    xfer(1'b1, 18'h12345, 2'b11, 16'h0000, 1'b0, r, w, d, o, v, u, l);
    chk("post_abort_rd_edge", v, 2 + Iob);

    repeat (3) @(negedge a_clk);
    chk("doe_oe_overlap", viol, 0);
    chk("vld_count", vld_seen, n_reads);
    chk("sb_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
